// File: rtl/dm_handover_ctrl.sv
// ---------------------------------------------------------------------------
// dm_handover_ctrl
//
// Handover controller for a device that can attach to one of three base
// stations (BS1..BS3). It low-pass filters the raw signal quality reported
// for each BS, attaches to the strongest BS once it is good enough, and
// decides on handovers when the serving BS asks for one. It also tracks
// link loss and counts successful handovers and acknowledge timeouts.
//
// Parameters
//   SQ_THRESH : minimum filtered SQ needed for the initial attach
//   HYST      : margin a candidate must exceed the serving SQ by
//   TIMEOUT   : cycles to wait for the target BS to acknowledge
//   LOSS_CYC  : consecutive respond-low cycles that declare link loss
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   meas_sq1..3    [7:0]  in      : raw signal quality of BS1..BS3
//   bs_dm_respond  [2:0]  in      : bit i = BS(i+1) is serving this device
//   bs_dm_request  [2:0]  in      : bit i = BS(i+1) requests a decision
//   bs_dm_data     [23:0] in      : payload, BS(i+1) on bits [8i+7:8i]
//   dm_bs1..3_sq   [7:0]  out     : filtered SQ reported to each BS
//   dm_bs_target   [1:0]  out     : target index (0..2 = BS1..BS3, 3 = none)
//   serving        [1:0]  out     : current serving index
//   serving_valid         out     : device attached
//   dm_rx_data     [7:0]  out     : registered payload from serving BS
//   dm_rx_valid           out     : dm_rx_data updated this cycle
//   ho_count       [7:0]  out     : successful handovers (saturating)
//   fail_count     [7:0]  out     : acknowledge timeouts (saturating)
// ---------------------------------------------------------------------------
module dm_handover_ctrl #(
  parameter int SQ_THRESH = 50,
  parameter int HYST      = 10,
  parameter int TIMEOUT   = 16,
  parameter int LOSS_CYC  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  meas_sq1,
  input  logic [7:0]  meas_sq2,
  input  logic [7:0]  meas_sq3,
  input  logic [2:0]  bs_dm_respond,
  input  logic [2:0]  bs_dm_request,
  input  logic [23:0] bs_dm_data,
  output logic [7:0]  dm_bs1_sq,
  output logic [7:0]  dm_bs2_sq,
  output logic [7:0]  dm_bs3_sq,
  output logic [1:0]  dm_bs_target,
  output logic [1:0]  serving,
  output logic        serving_valid,
  output logic [7:0]  dm_rx_data,
  output logic        dm_rx_valid,
  output logic [7:0]  ho_count,
  output logic [7:0]  fail_count
);

  // Timer only ever holds 0..TIMEOUT-1; loss counter holds 0..LOSS_CYC-1.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(LOSS_CYC + 1);

  localparam logic [1:0] NO_TARGET = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_CONNECTED,
    S_DECIDE,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      f1_q, f1_d;
  logic [7:0]      f2_q, f2_d;
  logic [7:0]      f3_q, f3_d;
  logic [1:0]      target_q, target_d;
  logic [1:0]      serving_q, serving_d;
  logic            serving_valid_q, serving_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      ho_count_q, ho_count_d;
  logic [7:0]      fail_count_q, fail_count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   loss_q, loss_d;

  logic [1:0]      best;
  logic [7:0]      f_best;
  logic [7:0]      f_serv;
  logic            resp_serv;
  logic            req_serv;
  logic            resp_tgt;
  logic [7:0]      data_serv;

  // f <= (3*f + meas) >> 2 in 10 bits; the result always fits in 8 bits.
  function automatic logic [7:0] sq_filter(input logic [7:0] f,
                                           input logic [7:0] meas);
    logic [9:0] acc;
    acc = ({2'b00, f} << 1) + {2'b00, f} + {2'b00, meas};
    return acc[9:2];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Strongest BS; strict '>' keeps ties on the lowest index.
  always_comb begin
    best   = 2'd0;
    f_best = f1_q;
    if (f2_q > f_best) begin
      best   = 2'd1;
      f_best = f2_q;
    end
    if (f3_q > f_best) begin
      best   = 2'd2;
      f_best = f3_q;
    end
  end

  // Per-BS views of the serving and target stations.
  always_comb begin
    f_serv    = f1_q;
    resp_serv = bs_dm_respond[0];
    req_serv  = bs_dm_request[0];
    data_serv = bs_dm_data[7:0];
    case (serving_q)
      2'd1: begin
        f_serv    = f2_q;
        resp_serv = bs_dm_respond[1];
        req_serv  = bs_dm_request[1];
        data_serv = bs_dm_data[15:8];
      end
      2'd2: begin
        f_serv    = f3_q;
        resp_serv = bs_dm_respond[2];
        req_serv  = bs_dm_request[2];
        data_serv = bs_dm_data[23:16];
      end
      default: ;
    endcase

    resp_tgt = 1'b0;
    case (target_q)
      2'd0:    resp_tgt = bs_dm_respond[0];
      2'd1:    resp_tgt = bs_dm_respond[1];
      2'd2:    resp_tgt = bs_dm_respond[2];
      default: resp_tgt = 1'b0;
    endcase
  end

  // Next-state logic for filters, data capture and the handover FSM.
  always_comb begin
    state_d         = state_q;
    target_d        = target_q;
    serving_d       = serving_q;
    serving_valid_d = serving_valid_q;
    ho_count_d      = ho_count_q;
    fail_count_d    = fail_count_q;
    timer_d         = timer_q;
    loss_d          = '0;

    f1_d = sq_filter(f1_q, meas_sq1);
    f2_d = sq_filter(f2_q, meas_sq2);
    f3_d = sq_filter(f3_q, meas_sq3);

    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (serving_valid_q && resp_serv) begin
      rx_data_d  = data_serv;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if ({1'b0, f_best} >= 9'(SQ_THRESH)) begin
          target_d = best;
          timer_d  = '0;
          state_d  = S_WAIT_ACK;
        end
      end

      // Acknowledge is tested first so it wins over a same-cycle timeout.
      S_WAIT_ACK: begin
        if (resp_tgt) begin
          if (serving_valid_q) begin
            ho_count_d = sat_inc(ho_count_q);
          end
          serving_d       = target_q;
          serving_valid_d = 1'b1;
          target_d        = NO_TARGET;
          state_d         = S_CONNECTED;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          fail_count_d = sat_inc(fail_count_q);
          target_d     = NO_TARGET;
          state_d      = serving_valid_q ? S_CONNECTED : S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      // Loss is tested first so it wins over a same-cycle request.
      S_CONNECTED: begin
        if (!resp_serv && (loss_q == LW'(LOSS_CYC - 1))) begin
          serving_valid_d = 1'b0;
          state_d         = S_IDLE;
        end else begin
          loss_d = resp_serv ? '0 : loss_q + 1'b1;
          if (req_serv) begin
            state_d = S_DECIDE;
          end
        end
      end

      S_DECIDE: begin
        if ((best != serving_q) &&
            ({1'b0, f_best} >= ({1'b0, f_serv} + 9'(HYST)))) begin
          target_d = best;
          timer_d  = '0;
          state_d  = S_WAIT_ACK;
        end else begin
          target_d = serving_q;
          state_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!req_serv) begin
          target_d = NO_TARGET;
          state_d  = S_CONNECTED;
        end
      end

      default: begin
        target_d = NO_TARGET;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      f1_q            <= '0;
      f2_q            <= '0;
      f3_q            <= '0;
      target_q        <= NO_TARGET;
      serving_q       <= '0;
      serving_valid_q <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      ho_count_q      <= '0;
      fail_count_q    <= '0;
      timer_q         <= '0;
      loss_q          <= '0;
    end else begin
      state_q         <= state_d;
      f1_q            <= f1_d;
      f2_q            <= f2_d;
      f3_q            <= f3_d;
      target_q        <= target_d;
      serving_q       <= serving_d;
      serving_valid_q <= serving_valid_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      ho_count_q      <= ho_count_d;
      fail_count_q    <= fail_count_d;
      timer_q         <= timer_d;
      loss_q          <= loss_d;
    end
  end

  assign dm_bs1_sq     = f1_q;
  assign dm_bs2_sq     = f2_q;
  assign dm_bs3_sq     = f3_q;
  assign dm_bs_target  = target_q;
  assign serving       = serving_q;
  assign serving_valid = serving_valid_q;
  assign dm_rx_data    = rx_data_q;
  assign dm_rx_valid   = rx_valid_q;
  assign ho_count      = ho_count_q;
  assign fail_count    = fail_count_q;

endmodule

// File: tb/tb_dm_handover_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_handover_ctrl
//
// Bench for dm_handover_ctrl: directed scenarios (attach, handover,
// hysteresis, timeout, link loss, reset mid-handover) followed by a long
// randomized run, all checked against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_dm_handover_ctrl;

  localparam int SQ_THRESH = 50;
  localparam int HYST      = 10;
  localparam int TIMEOUT   = 16;
  localparam int LOSS_CYC  = 4;

  localparam int M_IDLE = 0, M_WAIT = 1, M_CONN = 2, M_DECIDE = 3, M_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  meas_sq1, meas_sq2, meas_sq3;
  logic [2:0]  bs_dm_respond, bs_dm_request;
  logic [23:0] bs_dm_data;
  logic [7:0]  dm_bs1_sq, dm_bs2_sq, dm_bs3_sq;
  logic [1:0]  dm_bs_target, serving;
  logic        serving_valid;
  logic [7:0]  dm_rx_data;
  logic        dm_rx_valid;
  logic [7:0]  ho_count, fail_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (plain integers).
  int m_f[3];
  int m_mode, m_target, m_serv, m_sv, m_rx, m_rxv, m_ho, m_fail, m_timer, m_loss;

  logic [53:0] dut_vec;
  localparam logic [53:0] RESET_VEC = {24'd0, 2'd3, 2'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0};

  dm_handover_ctrl #(
    .SQ_THRESH(SQ_THRESH), .HYST(HYST), .TIMEOUT(TIMEOUT), .LOSS_CYC(LOSS_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .meas_sq1(meas_sq1), .meas_sq2(meas_sq2), .meas_sq3(meas_sq3),
    .bs_dm_respond(bs_dm_respond), .bs_dm_request(bs_dm_request),
    .bs_dm_data(bs_dm_data),
    .dm_bs1_sq(dm_bs1_sq), .dm_bs2_sq(dm_bs2_sq), .dm_bs3_sq(dm_bs3_sq),
    .dm_bs_target(dm_bs_target), .serving(serving), .serving_valid(serving_valid),
    .dm_rx_data(dm_rx_data), .dm_rx_valid(dm_rx_valid),
    .ho_count(ho_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {dm_bs1_sq, dm_bs2_sq, dm_bs3_sq, dm_bs_target, serving, serving_valid,
                    dm_rx_data, dm_rx_valid, ho_count, fail_count};

  function automatic logic [53:0] exp_vec();
    return {8'(m_f[0]), 8'(m_f[1]), 8'(m_f[2]), 2'(m_target), 2'(m_serv), 1'(m_sv),
            8'(m_rx), 1'(m_rxv), 8'(m_ho), 8'(m_fail)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_f[i] = 0;
    m_mode = M_IDLE; m_target = 3; m_serv = 0; m_sv = 0; m_rx = 0; m_rxv = 0;
    m_ho = 0; m_fail = 0; m_timer = 0; m_loss = 0;
  endtask

  // One rising edge of the behavioural model, using the inputs as sampled.
  task automatic model_step();
    int sq[3];
    int b;
    if (!reset_n) begin
      model_reset();
      return;
    end
    sq[0] = int'(meas_sq1); sq[1] = int'(meas_sq2); sq[2] = int'(meas_sq3);
    b = 0;
    for (int i = 1; i < 3; i++) if (m_f[i] > m_f[b]) b = i;

    if (m_sv != 0 && bs_dm_respond[m_serv]) begin
      m_rx  = int'((bs_dm_data >> (8 * m_serv)) & 24'hFF);
      m_rxv = 1;
    end else begin
      m_rxv = 0;
    end

    if (m_mode != M_CONN) m_loss = 0;
    case (m_mode)
      M_IDLE: if (m_f[b] >= SQ_THRESH) begin
        m_target = b; m_timer = 0; m_mode = M_WAIT;
      end
      M_WAIT: begin
        if (bs_dm_respond[m_target]) begin
          if (m_sv != 0 && m_ho < 255) m_ho++;
          m_serv = m_target; m_sv = 1; m_target = 3; m_mode = M_CONN;
        end else if (m_timer == TIMEOUT - 1) begin
          if (m_fail < 255) m_fail++;
          m_target = 3;
          m_mode = (m_sv != 0) ? M_CONN : M_IDLE;
        end else begin
          m_timer++;
        end
      end
      M_CONN: begin
        m_loss = bs_dm_respond[m_serv] ? 0 : m_loss + 1;
        if (m_loss == LOSS_CYC) begin
          m_sv = 0; m_mode = M_IDLE; m_loss = 0;
        end else if (bs_dm_request[m_serv]) begin
          m_mode = M_DECIDE;
        end
      end
      M_DECIDE: begin
        if (b != m_serv && m_f[b] >= m_f[m_serv] + HYST) begin
          m_target = b; m_timer = 0; m_mode = M_WAIT;
        end else begin
          m_target = m_serv; m_mode = M_HOLD;
        end
      end
      default: if (!bs_dm_request[m_serv]) begin
        m_target = 3; m_mode = M_CONN;
      end
    endcase

    for (int i = 0; i < 3; i++) m_f[i] = (3 * m_f[i] + sq[i]) / 4;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic set_meas(input int a, input int b, input int c);
    meas_sq1 = 8'(a); meas_sq2 = 8'(b); meas_sq3 = 8'(c);
  endtask

  task automatic do_reset();
    bs_dm_respond = 3'b000; bs_dm_request = 3'b000; bs_dm_data = 24'd0;
    set_meas(0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Attach to BS(idx+1) with its respond line held high.
  task automatic attach_to(input int idx);
    set_meas(idx == 0 ? 200 : 0, idx == 1 ? 200 : 0, idx == 2 ? 200 : 0);
    bs_dm_respond = 3'(1 << idx);
    for (int i = 0; i < 20 && !serving_valid; i++) cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (dut_vec !== RESET_VEC) $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_attach();
    do_reset();
    set_meas(0, 200, 0);
    for (int i = 0; i < 10 && dm_bs_target !== 2'd1; i++) cyc(1);
    n_total++;
    if (dm_bs_target !== 2'd1 || serving_valid !== 1'b0)
      $display("FAIL attach_target: got target %0d sv %0d expected target 1 sv 0", dm_bs_target, serving_valid);
    else n_pass++;
    bs_dm_respond = 3'b010;
    bs_dm_data = 24'h11AB22;
    cyc(1);
    n_total++;
    if ({serving, serving_valid, dm_bs_target, ho_count} !== {2'd1, 1'b1, 2'd3, 8'd0})
      $display("FAIL attach_ack: got serv %0d sv %0d tgt %0d ho %0d expected 1 1 3 0",
               serving, serving_valid, dm_bs_target, ho_count);
    else n_pass++;
    cyc(1);
    n_total++;
    if (dm_rx_valid !== 1'b1 || dm_rx_data !== 8'hAB)
      $display("FAIL attach_rx: got valid %0d data %h expected 1 ab", dm_rx_valid, dm_rx_data);
    else n_pass++;
  endtask

  // Continues from the BS2 attachment left by test_attach.
  task automatic test_handover();
    set_meas(0, 40, 120);
    cyc(40);
    bs_dm_request = 3'b010;
    cyc(1);
    bs_dm_request = 3'b000;
    n_total++;
    if (dm_bs_target !== 2'd3) $display("FAIL ho_decide_cycle: got %0d expected 3", dm_bs_target);
    else n_pass++;
    cyc(1);
    n_total++;
    if (dm_bs_target !== 2'd2) $display("FAIL ho_target: got %0d expected 2", dm_bs_target);
    else n_pass++;
    bs_dm_respond = 3'b110;
    cyc(1);
    n_total++;
    if ({serving, serving_valid, dm_bs_target, ho_count} !== {2'd2, 1'b1, 2'd3, 8'd1})
      $display("FAIL ho_ack: got serv %0d sv %0d tgt %0d ho %0d expected 2 1 3 1",
               serving, serving_valid, dm_bs_target, ho_count);
    else n_pass++;
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL ho_model: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    do_reset();
    attach_to(0);
    set_meas(60, 0, 65);
    cyc(40);
    bs_dm_request = 3'b101;  // BS3 request must be ignored
    cyc(2);
    n_total++;
    if (dm_bs_target !== 2'd0) $display("FAIL hyst_hold: got %0d expected 0", dm_bs_target);
    else n_pass++;
    cyc(3);
    n_total++;
    if (dm_bs_target !== 2'd0) $display("FAIL hyst_hold_long: got %0d expected 0", dm_bs_target);
    else n_pass++;
    bs_dm_request = 3'b100;
    cyc(1);
    n_total++;
    if ({dm_bs_target, serving, ho_count} !== {2'd3, 2'd0, 8'd0})
      $display("FAIL hyst_release: got tgt %0d serv %0d ho %0d expected 3 0 0", dm_bs_target, serving, ho_count);
    else n_pass++;
    bs_dm_request = 3'b000;
  endtask

  task automatic test_timeout();
    do_reset();
    attach_to(0);
    set_meas(60, 0, 200);
    cyc(20);
    bs_dm_request = 3'b001;
    cyc(1);
    bs_dm_request = 3'b000;
    cyc(1);
    n_total++;
    if (dm_bs_target !== 2'd2) $display("FAIL to_target: got %0d expected 2", dm_bs_target);
    else n_pass++;
    cyc(15);
    n_total++;
    if (dm_bs_target !== 2'd2 || fail_count !== 8'd0)
      $display("FAIL to_early: got tgt %0d fail %0d expected 2 0", dm_bs_target, fail_count);
    else n_pass++;
    cyc(1);
    n_total++;
    if ({dm_bs_target, fail_count, serving, serving_valid, ho_count} !== {2'd3, 8'd1, 2'd0, 1'b1, 8'd0})
      $display("FAIL to_expire: got tgt %0d fail %0d serv %0d sv %0d ho %0d expected 3 1 0 1 0",
               dm_bs_target, fail_count, serving, serving_valid, ho_count);
    else n_pass++;
  endtask

  task automatic test_link_loss();
    do_reset();
    attach_to(0);
    cyc(3);
    bs_dm_respond = 3'b000;
    cyc(LOSS_CYC - 1);
    n_total++;
    if (serving_valid !== 1'b1) $display("FAIL loss_early: got sv %0d expected 1", serving_valid);
    else n_pass++;
    bs_dm_request = 3'b001;
    cyc(1);
    n_total++;
    if ({serving_valid, dm_bs_target, dm_rx_valid} !== {1'b0, 2'd3, 1'b0})
      $display("FAIL loss_declared: got sv %0d tgt %0d rxv %0d expected 0 3 0",
               serving_valid, dm_bs_target, dm_rx_valid);
    else n_pass++;
    bs_dm_request = 3'b000;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_meas(200, 0, 0);
    for (int i = 0; i < 10 && dm_bs_target !== 2'd0; i++) cyc(1);
    cyc(3);
    reset_n = 1'b0;
    #1;
    n_total++;
    if (dut_vec !== RESET_VEC) $display("FAIL rst_async: got %h expected %h", dut_vec, RESET_VEC);
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    n_total++;
    if (dut_vec !== exp_vec()) $display("FAIL rst_resume: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 12 == 0) set_meas($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      for (int k = 0; k < 3; k++) begin
        bs_dm_respond[k] = ($urandom_range(0, 7) != 0);
        bs_dm_request[k] = ($urandom_range(0, 9) == 0);
      end
      bs_dm_data = 24'($urandom);
      cyc(1);
      n_total++;
      if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attach();
    test_handover();
    test_hysteresis();
    test_timeout();
    test_link_loss();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
